filter_frame_seq: RTL and testbench

FILTER_FRAME_SEQ -- requirements
Module: filter_frame_seq

---
 rtl/filter_frame_seq.sv | 108 ++++++++++
 tb/tb_filter_frame_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/filter_frame_seq.sv
// Frame sequencer for a KxK window filter: clears the datapath, walks col/row over accepted beats, then waits for results.
// in_ready is purely a function of state (high only in RUN); upstream beats stall while the sequencer clears, flushes or idles.
module filter_frame_seq #(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int Ope_Size  = 3,
    parameter int FLUSH_MAX = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [8:0]  op_out,
    output logic        reflesh,
    output logic        win_en,
    output logic [15:0] col,
    output logic [15:0] row,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [15:0] KM1        = 16'(Ope_Size - 1);
    localparam logic [15:0] COL_LAST   = 16'(IMG_W - 1);
    localparam logic [15:0] ROW_LAST   = 16'(IMG_H - 1);
    localparam logic [31:0] EXPECT     = 32'((IMG_W - Ope_Size + 1) * (IMG_H - Ope_Size + 1));
    localparam logic [31:0] FLUSH_LAST = 32'(FLUSH_MAX - 1);

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [31:0] out_cnt;
    logic [31:0] out_cnt_nxt;
    logic [31:0] timer;
    logic        accept;
    logic        last_beat;
    logic        res_vld;
    logic        unused_pix;

    assign unused_pix = ^op_out[7:0];

    assign in_ready  = (state == S_RUN);
    assign reflesh   = (state == S_CLEAR);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign accept    = in_valid & in_ready;
    assign last_beat = accept & (col == COL_LAST) & (row == ROW_LAST);
    assign win_en    = accept & (row >= KM1) & (col >= KM1);

    // Results count only while the datapath is live; the counter saturates instead of wrapping.
    assign res_vld     = op_out[8] & ((state == S_RUN) | (state == S_FLUSH));
    assign out_cnt_nxt = (res_vld && out_cnt != 32'hFFFF_FFFF) ? out_cnt + 32'd1 : out_cnt;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = S_RUN;
            S_RUN:   if (last_beat) state_nxt = S_FLUSH;
            // The result arriving this cycle is included, so a late final result beats the timeout.
            S_FLUSH: if (out_cnt_nxt >= EXPECT || timer == FLUSH_LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            col     <= '0;
            row     <= '0;
            out_cnt <= '0;
            timer   <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_CLEAR) begin
                col     <= '0;
                row     <= '0;
                out_cnt <= '0;
                timer   <= '0;
                err     <= 1'b0;
            end else begin
                out_cnt <= out_cnt_nxt;
                if (accept) begin
                    if (col == COL_LAST) begin
                        col <= '0;
                        row <= (row == ROW_LAST) ? 16'd0 : row + 16'd1;
                    end else begin
                        col <= col + 16'd1;
                    end
                end
                if (state == S_FLUSH) begin
                    timer <= timer + 32'd1;
                    if (out_cnt_nxt < EXPECT && timer == FLUSH_LAST)
                        err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_filter_frame_seq.sv
// Directed bench for filter_frame_seq on a 5x4 frame with a 3x3 window and a 16-cycle flush timeout.
module tb_filter_frame_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  op_out;
    logic        reflesh;
    logic        win_en;
    logic [15:0] col;
    logic [15:0] row;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    filter_frame_seq #(.IMG_W(5), .IMG_H(4), .Ope_Size(3), .FLUSH_MAX(16)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .op_out(op_out), .reflesh(reflesh), .win_en(win_en), .col(col), .row(row),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h @%0t", tag, obs, exp, $time);
        end
    endtask

    // Start pulse in IDLE, then the single CLEAR cycle.
    task automatic begin_frame();
        @(negedge clk); start = 1'b1; #1;
        check("idle_busy", busy, 0);
        check("idle_reflesh", reflesh, 0);
        @(negedge clk); start = 1'b0; #1;
        check("clr_reflesh", reflesh, 1);
        check("clr_busy", busy, 1);
        check("clr_ready", in_ready, 0);
    endtask

    // Offer beats from the first RUN cycle; op_out valid accompanies the first n_ops window beats.
    task automatic feed(input int n_beats, input bit gaps, input int n_ops, input bit start_in_run);
        int acc = 0;
        int wins = 0;
        int i = 0;
        int ec = 0;
        int er = 0;
        bit gap;
        bit ew;
        while (acc < n_beats && i < 200) begin
            @(negedge clk);
            gap      = gaps && ((i % 4) == 1 || (i % 7) == 3);
            in_valid = !gap;
            start    = start_in_run && (i == 5);
            ew       = !gap && er >= 2 && ec >= 2;
            op_out   = (ew && wins < n_ops) ? 9'h1AB : 9'h0AB;
            #1;
            if (i == 0) begin
                check("run_err", err, 0);
                check("run_reflesh", reflesh, 0);
            end
            check("ready", in_ready, 1);
            check("col", col, ec);
            check("row", row, er);
            check("win_en", win_en, ew);
            if (!gap) begin
                if (ew) wins++;
                acc++;
                if (ec == 4) begin
                    ec = 0;
                    er = (er == 3) ? 0 : er + 1;
                end else begin
                    ec++;
                end
            end
            i++;
        end
        check("beats_accepted", acc, n_beats);
        if (n_beats == 20) check("win_count", wins, 6);
    endtask

    // Counts cycles from FLUSH entry (k=0) to the done pulse; an op_out valid can be injected at cycle late_k.
    task automatic wait_done(input int exp_k, input bit exp_err, input int late_k, input bit start_in_done);
        int k = 0;
        int got = -1;
        while (k < 40 && got < 0) begin
            @(negedge clk);
            in_valid = 1'b0;
            op_out   = (k == late_k) ? 9'h100 : 9'h000;
            start    = start_in_done && (k == exp_k);
            #1;
            if (k == 0) begin
                check("flush_ready", in_ready, 0);
                check("flush_busy", busy, 1);
                check("flush_col", col, 0);
                check("flush_row", row, 0);
            end
            if (done) begin
                got = k;
                check("done_err", err, exp_err);
                check("done_busy", busy, 1);
            end
            k++;
        end
        check("done_latency", got, exp_k);
        @(negedge clk); start = 1'b0; op_out = 9'h000; #1;
        check("post_done", done, 0);
        check("post_busy", busy, 0);
        @(negedge clk); #1;
        check("idle_stays", busy, 0);
        check("idle_no_reflesh", reflesh, 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b1; in_valid = 1'b1; op_out = 9'h100;
        #1;
        check("rst_ready", in_ready, 0);
        check("rst_reflesh", reflesh, 0);
        check("rst_win", win_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_col", col, 0);
        check("rst_row", row, 0);
        @(negedge clk); start = 1'b0; in_valid = 1'b0; op_out = 9'h000;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;
        check("idle_after_rst", busy, 0);

        // Back-to-back beats, all six results during RUN.
        begin_frame();
        feed(20, 1'b0, 6, 1'b0);
        wait_done(1, 1'b0, -1, 1'b0);

        // Gapped beats, with start held mid-RUN which must be ignored.
        begin_frame();
        feed(20, 1'b1, 6, 1'b1);
        wait_done(1, 1'b0, -1, 1'b1);

        // One result short: timeout after 16 flush cycles, err set.
        begin_frame();
        feed(20, 1'b0, 5, 1'b0);
        wait_done(16, 1'b1, -1, 1'b0);
        check("err_sticky", err, 1);

        // Next start clears err; sixth result lands on the timeout cycle.
        begin_frame();
        feed(20, 1'b0, 5, 1'b0);
        wait_done(16, 1'b0, 15, 1'b0);

        // Reset mid-frame after 7 accepted beats.
        begin_frame();
        feed(7, 1'b0, 6, 1'b0);
        @(negedge clk); in_valid = 1'b1; rst = 1'b0; #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_col", col, 0);
        check("mid_rst_row", row, 0);
        @(negedge clk); in_valid = 1'b0; rst = 1'b1; #1;
        check("mid_rst_idle", busy, 0);
        @(negedge clk); #1;
        check("no_done_after_rst", done, 0);
        begin_frame();
        feed(20, 1'b0, 6, 1'b0);
        wait_done(1, 1'b0, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
